// File: rtl/layer_vec_driver.sv
// Stream-side driver for one fully connected layer instance.
// Buffers an N-word input vector from the host, streams it into the layer,
// collects the M result words and replays them to the host.
// Words are signed two's complement and pass through bit-exact.
module layer_vec_driver #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int T    = 8,
  parameter int LOGN = 3,
  parameter int LOGM = 3
) (
  input  logic                clk,
  input  logic                reset,
  // host load side
  input  logic                ld_valid,
  input  logic signed [T-1:0] ld_data,
  output logic                ld_ready,
  // to layer input port
  output logic                tx_valid,
  output logic signed [T-1:0] tx_data,
  input  logic                tx_ready,
  // from layer output port
  input  logic                rx_valid,
  input  logic signed [T-1:0] rx_data,
  output logic                rx_ready,
  // host result side
  output logic                res_valid,
  output logic signed [T-1:0] res_data,
  input  logic                res_ready,
  // status
  output logic                done,
  output logic [7:0]          vec_count,
  output logic                neg_seen
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_RECV  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [LOGN:0] N_LAST = (LOGN+1)'(N-1);
  localparam logic [LOGM:0] M_LAST = (LOGM+1)'(M-1);
  localparam logic [LOGN:0] N_ONE  = (LOGN+1)'(1);
  localparam logic [LOGM:0] M_ONE  = (LOGM+1)'(1);

  logic [1:0]          state;
  logic [LOGN:0]       ld_cnt;
  logic [LOGN:0]       tx_cnt;
  logic [LOGM:0]       rx_cnt;
  logic [LOGM:0]       res_cnt;

  // Vector storage; never reset, the counters alone define what is valid.
  logic signed [T-1:0] x_buf [N];
  logic signed [T-1:0] y_buf [M];

  logic                ld_fire;
  logic                tx_fire;
  logic                rx_fire;
  logic                res_fire;

  // Handshake outputs come straight from the state and are forced low during reset.
  always_comb begin
    ld_ready  = !reset && (state == S_LOAD);
    tx_valid  = !reset && (state == S_SEND);
    rx_ready  = !reset && (state == S_RECV);
    res_valid = !reset && (state == S_DRAIN);
    ld_fire   = ld_valid  && ld_ready;
    tx_fire   = tx_valid  && tx_ready;
    rx_fire   = rx_valid  && rx_ready;
    res_fire  = res_valid && res_ready;
    tx_data   = tx_valid  ? x_buf[tx_cnt[LOGN-1:0]]  : '0;
    res_data  = res_valid ? y_buf[res_cnt[LOGM-1:0]] : '0;
  end

  // Data capture into the vector buffers (no reset on data).
  always_ff @(posedge clk) begin
    if (ld_fire) x_buf[ld_cnt[LOGN-1:0]] <= ld_data;
    if (rx_fire) y_buf[rx_cnt[LOGM-1:0]] <= rx_data;
  end

  // Control FSM: LOAD -> SEND -> RECV -> DRAIN -> LOAD, plus status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      ld_cnt    <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      res_cnt   <= '0;
      done      <= 1'b0;
      vec_count <= 8'd0;
      neg_seen  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          if (ld_fire) begin
            if (ld_cnt == N_LAST) begin
              ld_cnt <= '0;
              state  <= S_SEND;
            end else begin
              ld_cnt <= ld_cnt + N_ONE;
            end
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            if (tx_cnt == N_LAST) begin
              tx_cnt <= '0;
              state  <= S_RECV;
            end else begin
              tx_cnt <= tx_cnt + N_ONE;
            end
          end
        end
        S_RECV: begin
          if (rx_fire) begin
            if (rx_cnt == M_LAST) begin
              rx_cnt <= '0;
              state  <= S_DRAIN;
            end else begin
              rx_cnt <= rx_cnt + M_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (res_fire) begin
            if (res_cnt == M_LAST) begin
              res_cnt   <= '0;
              done      <= 1'b1;
              vec_count <= vec_count + 8'd1;
              state     <= S_LOAD;
            end else begin
              res_cnt <= res_cnt + M_ONE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
      // A negative layer output means the ReLU stage misbehaved; remember it.
      if (rx_fire && rx_data[T-1]) neg_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_vec_driver.sv
// Self-checking bench for layer_vec_driver: scoreboard queues hold the words
// each port is expected to emit, filled as stimulus is accepted.
module tb_layer_vec_driver;
  localparam int N = 8;
  localparam int M = 8;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ld_valid = 1'b0;
  logic [T-1:0] ld_data = '0;
  logic         ld_ready;
  logic         tx_valid;
  logic [T-1:0] tx_data;
  logic         tx_ready = 1'b0;
  logic         rx_valid = 1'b0;
  logic [T-1:0] rx_data = '0;
  logic         rx_ready;
  logic         res_valid;
  logic [T-1:0] res_data;
  logic         res_ready = 1'b0;
  logic         done;
  logic [7:0]   vec_count;
  logic         neg_seen;

  always #5 clk = ~clk;

  layer_vec_driver #(.N(N), .M(M), .T(T), .LOGN(3), .LOGM(3)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .done(done), .vec_count(vec_count), .neg_seen(neg_seen)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [T-1:0] xv [N];
  logic [T-1:0] yv [M];
  bit           exp_done  = 1'b0;
  bit           neg_model = 1'b0;
  logic [7:0]   vec_model = 8'd0;
  int           cyc_g = 0;
  int           last_ld_cyc, first_tx_cyc, last_tx_cyc, last_rx_cyc, first_resv_cyc;

  // Runs one vector through the DUT with the given stall pattern, checking
  // every port against the scoreboards each cycle. Entered and left just
  // after a falling edge.
  task automatic run_vec(input int tx_toggle, input int rx_gap, input int stall_at,
                         input int stall_len, input bit stray, input int abort_tx);
    logic [T-1:0] tx_q[$];
    logic [T-1:0] res_q[$];
    int ld_i = 0, tx_i = 0, rx_i = 0, res_i = 0, rx_wait = 0;
    int stall_left = stall_len;
    bit finished = 1'b0, last_fire, neg_next, tx_seen = 1'b0, resv_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      #1;
      check_cnt++; if (done !== exp_done) $display("FAIL done: got %b want %b", done, exp_done); else pass_cnt++;
      check_cnt++; if (neg_seen !== neg_model) $display("FAIL neg_seen: got %b want %b", neg_seen, neg_model); else pass_cnt++;
      check_cnt++; if (vec_count !== vec_model) $display("FAIL vec_count: got %0d want %0d", vec_count, vec_model); else pass_cnt++;
      if (!tx_valid) begin
        check_cnt++; if (tx_data !== '0) $display("FAIL tx_gate: got %h want 00", tx_data); else pass_cnt++;
      end
      if (!res_valid) begin
        check_cnt++; if (res_data !== '0) $display("FAIL res_gate: got %h want 00", res_data); else pass_cnt++;
      end
      if (res_valid && !resv_seen) begin resv_seen = 1'b1; first_resv_cyc = cyc_g; end
      if (res_i >= M || (abort_tx >= 0 && tx_i >= abort_tx)) begin finished = 1'b1; break; end
      // drive this cycle's inputs
      ld_valid = 1'b0;
      if (ld_i < N) begin ld_valid = 1'b1; ld_data = xv[ld_i]; end
      else if (stray && res_i < M) begin ld_valid = 1'($urandom_range(0, 1)); ld_data = T'($urandom); end
      tx_ready = (tx_toggle != 0) ? (cyc_g % 2 == 0) : 1'b1;
      rx_valid = 1'b0;
      if (rx_i < M) begin
        if (rx_wait > 0) rx_wait--;
        else begin rx_valid = 1'b1; rx_data = yv[rx_i]; end
      end else if (stray && res_i < M) begin
        rx_valid = 1'($urandom_range(0, 1)); rx_data = T'($urandom) | 8'h80;
      end
      res_ready = 1'b1;
      if (res_valid && res_i == stall_at && stall_left > 0) begin res_ready = 1'b0; stall_left--; end
      #1;
      last_fire = 1'b0;
      neg_next  = neg_model;
      if (ld_valid && ld_ready) begin
        check_cnt++;
        if (ld_i >= N) $display("FAIL stray_ld: accepted word %h outside load", ld_data);
        else begin pass_cnt++; tx_q.push_back(ld_data); last_ld_cyc = cyc_g; end
        ld_i++;
      end
      if (tx_valid) begin
        check_cnt++;
        if (tx_q.size() == 0) $display("FAIL tx_extra: got %h want no word", tx_data);
        else if (tx_data !== tx_q[0]) $display("FAIL tx_data: got %h want %h", tx_data, tx_q[0]);
        else pass_cnt++;
        if (tx_ready) begin
          if (tx_q.size() > 0) void'(tx_q.pop_front());
          if (!tx_seen) begin tx_seen = 1'b1; first_tx_cyc = cyc_g; end
          last_tx_cyc = cyc_g;
          tx_i++;
        end
      end
      if (rx_valid && rx_ready) begin
        check_cnt++;
        if (rx_i >= M) $display("FAIL stray_rx: accepted word %h outside recv", rx_data);
        else begin
          pass_cnt++; res_q.push_back(rx_data);
          if (rx_data[T-1]) neg_next = 1'b1;
          last_rx_cyc = cyc_g; rx_wait = rx_gap;
        end
        rx_i++;
      end
      if (res_valid) begin
        check_cnt++;
        if (res_q.size() == 0) $display("FAIL res_extra: got %h want no word", res_data);
        else if (res_data !== res_q[0]) $display("FAIL res_data: got %h want %h", res_data, res_q[0]);
        else pass_cnt++;
        if (res_ready) begin
          if (res_q.size() > 0) void'(res_q.pop_front());
          res_i++;
          if (res_i == M) last_fire = 1'b1;
        end
      end
      @(posedge clk);
      cyc_g++;
      exp_done  = last_fire;
      if (last_fire) vec_model = vec_model + 8'd1;
      neg_model = neg_next;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rx_valid = 1'b0;
    check_cnt++; if (!finished) $display("FAIL timeout: got unfinished vector want completion"); else pass_cnt++;
    if (finished && abort_tx < 0) begin
      check_cnt++;
      if (tx_i != N || rx_i != M) $display("FAIL word_counts: got tx %0d rx %0d want %0d %0d", tx_i, rx_i, N, M);
      else pass_cnt++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; ld_valid = 1'b0; rx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    exp_done = 1'b0; neg_model = 1'b0; vec_model = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    check_cnt++; if ({ld_ready, tx_valid, rx_ready, res_valid} !== 4'b0) $display("FAIL rst_hs: got %b want 0000", {ld_ready, tx_valid, rx_ready, res_valid}); else pass_cnt++;
    check_cnt++; if ({tx_data, res_data} !== '0) $display("FAIL rst_data: got %h %h want 00 00", tx_data, res_data); else pass_cnt++;
    check_cnt++; if ({done, neg_seen, vec_count} !== '0) $display("FAIL rst_status: got %b %b %0d want 0 0 0", done, neg_seen, vec_count); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; #1;
    check_cnt++; if (ld_ready !== 1'b1 || tx_valid !== 1'b0) $display("FAIL rst_load: got ld_ready %b tx_valid %b want 1 0", ld_ready, tx_valid); else pass_cnt++;
    exp_done = 1'b0; neg_model = 1'b0; vec_model = 8'd0;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < N; i++) xv[i] = T'(i + 1);
    for (int i = 0; i < M; i++) yv[i] = T'(i + 10);
    run_vec(0, 0, -1, 0, 1'b0, -1);
    check_cnt++; if (first_tx_cyc - last_ld_cyc != 1) $display("FAIL tx_latency: got %0d want 1", first_tx_cyc - last_ld_cyc); else pass_cnt++;
    check_cnt++; if (last_tx_cyc - first_tx_cyc != N - 1) $display("FAIL tx_burst: got %0d want %0d", last_tx_cyc - first_tx_cyc, N - 1); else pass_cnt++;
    check_cnt++; if (first_resv_cyc - last_rx_cyc != 1) $display("FAIL res_latency: got %0d want 1", first_resv_cyc - last_rx_cyc); else pass_cnt++;
    check_cnt++; if (vec_count !== 8'd1 || neg_seen !== 1'b0) $display("FAIL nominal_status: got %0d %b want 1 0", vec_count, neg_seen); else pass_cnt++;
  endtask

  task automatic test_tx_backpressure();
    for (int i = 0; i < N; i++) xv[i] = T'(8'h40 + i);
    for (int i = 0; i < M; i++) yv[i] = T'(8'h20 + 3 * i);
    run_vec(1, 0, -1, 0, 1'b0, -1);
    check_cnt++; if (vec_count !== 8'd2) $display("FAIL bp_count: got %0d want 2", vec_count); else pass_cnt++;
  endtask

  task automatic test_stalls();
    for (int i = 0; i < N; i++) xv[i] = T'(8'h7F - i);
    for (int i = 0; i < M; i++) yv[i] = T'(8'h30 + i);
    run_vec(0, 3, 4, 5, 1'b0, -1);
    check_cnt++; if (vec_count !== 8'd3) $display("FAIL stall_count: got %0d want 3", vec_count); else pass_cnt++;
  endtask

  task automatic test_relu();
    for (int i = 0; i < N; i++) xv[i] = T'(i * 5);
    for (int i = 0; i < M; i++) yv[i] = T'(8'h50 + i);
    yv[3] = 8'h85;
    run_vec(0, 0, -1, 0, 1'b0, -1);
    check_cnt++; if (neg_seen !== 1'b1) $display("FAIL relu_flag: got %b want 1", neg_seen); else pass_cnt++;
    yv[3] = 8'h05;
    run_vec(0, 1, -1, 0, 1'b0, -1);
    check_cnt++; if (neg_seen !== 1'b1) $display("FAIL relu_sticky: got %b want 1", neg_seen); else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    for (int i = 0; i < N; i++) xv[i] = T'(8'hA0 + i);
    for (int i = 0; i < M; i++) yv[i] = T'(i);
    run_vec(0, 0, -1, 0, 1'b0, 4);
    reset = 1'b1; #1;
    check_cnt++; if ({ld_ready, tx_valid, rx_ready, res_valid} !== 4'b0 || tx_data !== '0) $display("FAIL mid_rst_gate: got %b %h want 0000 00", {ld_ready, tx_valid, rx_ready, res_valid}, tx_data); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; #1;
    check_cnt++; if ({ld_ready, tx_valid, rx_ready, res_valid} !== 4'b1000) $display("FAIL mid_rst_load: got %b want 1000", {ld_ready, tx_valid, rx_ready, res_valid}); else pass_cnt++;
    check_cnt++; if (vec_count !== 8'd0 || neg_seen !== 1'b0) $display("FAIL mid_rst_status: got %0d %b want 0 0", vec_count, neg_seen); else pass_cnt++;
    exp_done = 1'b0; neg_model = 1'b0; vec_model = 8'd0;
    for (int i = 0; i < N; i++) xv[i] = T'(i + 9);
    run_vec(0, 0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    do_reset(2);
    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < N; i++) xv[i] = T'($urandom);
      for (int i = 0; i < M; i++) yv[i] = T'($urandom);
      run_vec(v % 2, v % 3, v % M, v % 4, 1'b1, -1);
      if (v == 254) begin
        check_cnt++; if (vec_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", vec_count); else pass_cnt++;
      end
    end
    check_cnt++; if (vec_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", vec_count); else pass_cnt++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_tx_backpressure();
    test_stalls();
    test_relu();
    test_reset_mid_send();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
